// File: rtl/cbctdes_pkg.sv
// Shared types for the cbctdes host-side controller.
//   BLK_W        : cipher block width (64)
//   state_t      : controller FSM states
//   obuf_entry_t : output buffer entry {last, data}
package cbctdes_pkg;

    localparam int unsigned BLK_W = 64;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic             last;
        logic [BLK_W-1:0] data;
    } obuf_entry_t;

endpackage

// File: rtl/cbctdes_ctrl_obuf.sv
// Output buffer for cbctdes_ctrl: small synchronous FIFO of {last, data}.
// Ports:
//   clk_i, reset_i : clock, async active-low reset (flushes the FIFO)
//   push_i, push_data_i : write one entry
//   pop_i          : consume the head entry
//   head_o         : head entry, forced to zero while empty
//   empty_o        : FIFO empty
//   count_o        : current occupancy, feeds the controller's credit check
module cbctdes_ctrl_obuf
    import cbctdes_pkg::*;
#(
    parameter int unsigned DEPTH = 2
)
(
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  obuf_entry_t              push_data_i,
    input  logic                     pop_i,
    output obuf_entry_t              head_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    obuf_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    // A push into a full FIFO is accepted when the head leaves in the same cycle.
    assign do_push = push_i && ((count_q != FULL) || do_pop);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr_q] <= push_data_i;
    end

    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = empty_o ? '0 : mem[rd_ptr_q];

endmodule

// File: rtl/cbctdes_ctrl.sv
// cbctdes_ctrl: host-side initiator for the cbctdes core.
// Accepts one message command (mode, keys, IV, block count), streams blocks
// from an upstream valid/ready source into the core (start on the first block),
// buffers core results and presents them downstream with a last flag.
// Ports:
//   clk_i, reset_i           : clock, async active-low reset
//   cmd_*                    : command handshake and fields (accepted in IDLE only)
//   s_data_i/s_valid_i/s_ready_o : upstream block stream
//   m_data_o/m_valid_o/m_last_o/m_ready_i : downstream result stream
//   core_*_o / core_*_i      : interface to the cbctdes core
//   busy_o                   : message in progress
//   done_o                   : one-cycle pulse once a message has fully drained
// Configuration macro CBCTDES_CTRL_CHAIN_EN adds cmd_chain_i / iv_next_o so a
// message can continue the CBC chain of the previous one.
module cbctdes_ctrl
    import cbctdes_pkg::*;
#(
    parameter int unsigned LEN_W      = 16,
    parameter int unsigned OBUF_DEPTH = 2
)
(
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_mode_i,
    input  logic [BLK_W-1:0] cmd_key1_i,
    input  logic [BLK_W-1:0] cmd_key2_i,
    input  logic [BLK_W-1:0] cmd_key3_i,
    input  logic [BLK_W-1:0] cmd_iv_i,
    input  logic [LEN_W-1:0] cmd_nblk_i,
    input  logic [BLK_W-1:0] s_data_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    output logic [BLK_W-1:0] m_data_o,
    output logic             m_valid_o,
    output logic             m_last_o,
    input  logic             m_ready_i,
    output logic             core_start_o,
    output logic             core_mode_o,
    output logic [BLK_W-1:0] core_key1_o,
    output logic [BLK_W-1:0] core_key2_o,
    output logic [BLK_W-1:0] core_key3_o,
    output logic [BLK_W-1:0] core_iv_o,
    output logic [BLK_W-1:0] core_data_o,
    output logic             core_valid_o,
    input  logic             core_ready_i,
    input  logic [BLK_W-1:0] core_data_i,
    input  logic             core_valid_i,
    output logic             busy_o,
    output logic             done_o
`ifdef CBCTDES_CTRL_CHAIN_EN
    ,
    input  logic             cmd_chain_i,
    output logic [BLK_W-1:0] iv_next_o
`endif
);

    localparam int unsigned CNT_W = $clog2(OBUF_DEPTH) + 1;

    state_t           state_q;
    state_t           state_d;

    logic             mode_q;
    logic [BLK_W-1:0] key1_q;
    logic [BLK_W-1:0] key2_q;
    logic [BLK_W-1:0] key3_q;
    logic [BLK_W-1:0] iv_q;
    logic [LEN_W-1:0] remaining_q;
    logic             first_q;
    logic             done_q;

    logic [BLK_W-1:0] iv_sel;
    logic             cmd_fire;
    logic             blk_fire;
    logic             res_fire;
    logic             inflight;
    logic             credit;
    logic [CNT_W:0]   occupied;

    obuf_entry_t      ob_push_data;
    obuf_entry_t      ob_head;
    logic             ob_empty;
    logic             ob_pop;
    logic [CNT_W-1:0] ob_count;

    // ------------------------------------------------------------------
    // Handshake qualifiers
    // ------------------------------------------------------------------
    assign cmd_fire = (state_q == IDLE) && cmd_valid_i;
    assign blk_fire = core_valid_o;
    // Results outside WAIT are protocol violations and are dropped.
    assign res_fire = (state_q == WAIT) && core_valid_i;
    assign inflight = (state_q == WAIT);

    // Issue only if the result of this block plus any pending one is sure to fit.
    assign occupied = {1'b0, ob_count} + {{CNT_W{1'b0}}, inflight};
    assign credit   = occupied < (CNT_W+1)'(OBUF_DEPTH);

`ifdef CBCTDES_CTRL_CHAIN_EN
    logic [BLK_W-1:0] iv_next_q;
    logic [BLK_W-1:0] last_in_q;
    logic [BLK_W-1:0] last_out_q;

    assign iv_sel = cmd_chain_i ? iv_next_q : cmd_iv_i;

    // Chaining value is the last ciphertext seen: the core output when
    // encrypting, the input block when decrypting. first_q still set at
    // DONE means an empty message, which leaves the chain untouched.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            iv_next_q  <= '0;
            last_in_q  <= '0;
            last_out_q <= '0;
        end else begin
            if (blk_fire) last_in_q  <= s_data_i;
            if (res_fire) last_out_q <= core_data_i;
            if ((state_q == DONE) && !first_q)
                iv_next_q <= mode_q ? last_in_q : last_out_q;
        end
    end

    assign iv_next_o = iv_next_q;
`else
    assign iv_sel = cmd_iv_i;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (cmd_valid_i) state_d = (cmd_nblk_i == '0) ? DONE : ISSUE;
            ISSUE: if (blk_fire)    state_d = WAIT;
            WAIT:  if (core_valid_i)
                       state_d = (remaining_q == LEN_W'(1)) ? DRAIN : ISSUE;
            DRAIN: if (ob_empty)    state_d = DONE;
            DONE:                   state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        cmd_ready_o  = (state_q == IDLE);
        busy_o       = (state_q != IDLE);
        s_ready_o    = (state_q == ISSUE) && core_ready_i && credit;
        core_valid_o = s_valid_i && s_ready_o;
        core_start_o = core_valid_o && first_q;
        core_data_o  = (state_q == ISSUE) ? s_data_i : '0;
    end

    // ------------------------------------------------------------------
    // Message registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            mode_q      <= 1'b0;
            key1_q      <= '0;
            key2_q      <= '0;
            key3_q      <= '0;
            iv_q        <= '0;
            remaining_q <= '0;
            first_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= (state_q == DONE);
            if (cmd_fire) begin
                mode_q      <= cmd_mode_i;
                key1_q      <= cmd_key1_i;
                key2_q      <= cmd_key2_i;
                key3_q      <= cmd_key3_i;
                iv_q        <= iv_sel;
                remaining_q <= cmd_nblk_i;
                first_q     <= 1'b1;
            end else begin
                if (blk_fire) first_q     <= 1'b0;
                if (res_fire) remaining_q <= remaining_q - 1'b1;
            end
        end
    end

    assign core_mode_o = mode_q;
    assign core_key1_o = key1_q;
    assign core_key2_o = key2_q;
    assign core_key3_o = key3_q;
    assign core_iv_o   = iv_q;
    assign done_o      = done_q;

    // ------------------------------------------------------------------
    // Output buffer
    // ------------------------------------------------------------------
    assign ob_push_data.last = (remaining_q == LEN_W'(1));
    assign ob_push_data.data = core_data_i;
    assign ob_pop            = m_valid_o && m_ready_i;

    cbctdes_ctrl_obuf #(
        .DEPTH (OBUF_DEPTH)
    ) u_obuf (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .push_i      (res_fire),
        .push_data_i (ob_push_data),
        .pop_i       (ob_pop),
        .head_o      (ob_head),
        .empty_o     (ob_empty),
        .count_o     (ob_count)
    );

    assign m_valid_o = !ob_empty;
    assign m_data_o  = ob_head.data;
    assign m_last_o  = ob_head.last;

endmodule

// File: tb/tb_cbctdes_ctrl.sv
// Scoreboard bench for cbctdes_ctrl. A behavioural core stub answers known
// TDES vectors (all keys equal, so TDES reduces to DES) and inverts any other
// block; expected results are queued at block issue and popped by a monitor.
module tb_cbctdes_ctrl;

    localparam logic [63:0] K  = 64'h0123456789ABCDEF;
    localparam logic [63:0] IV = 64'h1234567890ABCDEF;
    localparam logic [63:0] P1 = 64'h4E6F772069732074;
    localparam logic [63:0] P2 = 64'h68652074696D6520;
    localparam logic [63:0] P3 = 64'h666F7220616C6C20;
    localparam logic [63:0] C1 = 64'hE5C7CDDE872BF27C;
    localparam logic [63:0] C2 = 64'h43E934008C389C0F;
    localparam logic [63:0] C3 = 64'h683788499A7C05F6;

    logic        clk = 1'b0;
    logic        reset_i = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_mode_i = 1'b0;
    logic [63:0] cmd_key1_i = '0;
    logic [63:0] cmd_key2_i = '0;
    logic [63:0] cmd_key3_i = '0;
    logic [63:0] cmd_iv_i = '0;
    logic [15:0] cmd_nblk_i = '0;
    logic [63:0] s_data_i = '0;
    logic        s_valid_i = 1'b0;
    logic        s_ready_o;
    logic [63:0] m_data_o;
    logic        m_valid_o;
    logic        m_last_o;
    logic        m_ready_i = 1'b1;
    logic        core_start_o;
    logic        core_mode_o;
    logic [63:0] core_key1_o, core_key2_o, core_key3_o, core_iv_o, core_data_o;
    logic        core_valid_o;
    logic        core_ready_i = 1'b1;
    logic [63:0] core_data_i = '0;
    logic        core_valid_i = 1'b0;
    logic        busy_o;
    logic        done_o;
`ifdef CBCTDES_CTRL_CHAIN_EN
    logic        cmd_chain_i = 1'b0;
    logic [63:0] iv_next_o;
`endif

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          stub_issued = 0;
    int          msg_base = 0;
    logic        exp_mode = 1'b0;
    logic [63:0] exp_iv = '0;
    logic [64:0] sb [$];
    logic [64:0] mon_e;
    logic [63:0] blk   [8];
    logic [63:0] exp_d [8];
    logic        stub_busy = 1'b0;
    int          stub_cnt = 0;
    logic [63:0] stub_res = '0;

    cbctdes_ctrl #(
        .LEN_W      (16),
        .OBUF_DEPTH (2)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_mode_i   (cmd_mode_i),
        .cmd_key1_i   (cmd_key1_i),
        .cmd_key2_i   (cmd_key2_i),
        .cmd_key3_i   (cmd_key3_i),
        .cmd_iv_i     (cmd_iv_i),
        .cmd_nblk_i   (cmd_nblk_i),
        .s_data_i     (s_data_i),
        .s_valid_i    (s_valid_i),
        .s_ready_o    (s_ready_o),
        .m_data_o     (m_data_o),
        .m_valid_o    (m_valid_o),
        .m_last_o     (m_last_o),
        .m_ready_i    (m_ready_i),
        .core_start_o (core_start_o),
        .core_mode_o  (core_mode_o),
        .core_key1_o  (core_key1_o),
        .core_key2_o  (core_key2_o),
        .core_key3_o  (core_key3_o),
        .core_iv_o    (core_iv_o),
        .core_data_o  (core_data_o),
        .core_valid_o (core_valid_o),
        .core_ready_i (core_ready_i),
        .core_data_i  (core_data_i),
        .core_valid_i (core_valid_i),
        .busy_o       (busy_o),
        .done_o       (done_o)
`ifdef CBCTDES_CTRL_CHAIN_EN
        ,
        .cmd_chain_i  (cmd_chain_i),
        .iv_next_o    (iv_next_o)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout, required handshake", name);
    endtask

    function automatic logic [63:0] ref_core(input logic mode, input logic [63:0] d);
        logic [63:0] r;
        r = ~d;
        if (!mode) begin
            if (d == P1) r = C1;
            if (d == P2) r = C2;
            if (d == P3) r = C3;
        end else begin
            if (d == C1) r = P1;
            if (d == C2) r = P2;
            if (d == C3) r = P3;
        end
        return r;
    endfunction

    // Core stub: one block at a time, result 3 cycles after the issue edge.
    always begin
        @(negedge clk);
        if (!reset_i) begin
            core_valid_i = 1'b0;
            core_ready_i = 1'b1;
            stub_busy    = 1'b0;
        end else begin
            core_valid_i = 1'b0;
            if (core_valid_o && stub_busy) begin
                checks++;
                errors++;
                $display("FAIL core_overlap: got second block %h, required none in flight", core_data_o);
            end
            if (stub_busy) begin
                if (stub_cnt == 0) begin
                    core_data_i  = stub_res;
                    core_valid_i = 1'b1;
                    core_ready_i = 1'b1;
                    stub_busy    = 1'b0;
                end else begin
                    stub_cnt--;
                end
            end else if (core_valid_o) begin
                check("core_start", 64'(core_start_o), 64'(stub_issued == msg_base));
                check("core_mode", 64'(core_mode_o), 64'(exp_mode));
                check("core_key1", core_key1_o, K);
                check("core_key3", core_key3_o, K);
                if (stub_issued == msg_base) check("core_iv", core_iv_o, exp_iv);
                stub_res  = ref_core(core_mode_o, core_data_o);
                stub_issued++;
                stub_cnt  = 2;
                stub_busy = 1'b1;
                @(posedge clk);
                #1;
                if (reset_i) core_ready_i = 1'b0;
                else         stub_busy    = 1'b0;
            end
        end
    end

    // Result monitor: pops the scoreboard on every downstream transfer.
    always @(negedge clk) begin
        if (reset_i && m_valid_o && m_ready_i) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %h, required no output", m_data_o);
            end else begin
                mon_e = sb.pop_front();
                check("m_data", m_data_o, mon_e[63:0]);
                check("m_last", 64'(m_last_o), 64'(mon_e[64]));
            end
        end
    end

    always @(negedge clk) if (done_o) done_cnt++;

    task automatic send_cmd(input logic mode, input int unsigned nblk, input logic [63:0] iv,
                            input logic chain, input logic [63:0] iv_exp);
        bit ok;
        cmd_valid_i = 1'b1;
        cmd_mode_i  = mode;
        cmd_key1_i  = K;
        cmd_key2_i  = K;
        cmd_key3_i  = K;
        cmd_iv_i    = iv;
        cmd_nblk_i  = 16'(nblk);
`ifdef CBCTDES_CTRL_CHAIN_EN
        cmd_chain_i = chain;
`endif
        exp_mode = mode;
        exp_iv   = chain ? iv_exp : iv;
        msg_base = stub_issued;
        ok = 1'b0;
        for (int unsigned n = 0; n < 100; n++) begin
            @(negedge clk);
            if (cmd_ready_o) begin ok = 1'b1; break; end
        end
        if (!ok) timeout("cmd_ready_wait");
        @(posedge clk);
        #1;
        cmd_valid_i = 1'b0;
`ifdef CBCTDES_CTRL_CHAIN_EN
        cmd_chain_i = 1'b0;
`endif
    endtask

    task automatic send_blocks(input int unsigned first, input int unsigned cnt, input int unsigned last_idx);
        bit ok;
        for (int unsigned i = first; i < first + cnt; i++) begin
            s_valid_i = 1'b1;
            s_data_i  = blk[i];
            ok = 1'b0;
            for (int unsigned n = 0; n < 300; n++) begin
                @(negedge clk);
                if (s_ready_o) begin ok = 1'b1; break; end
            end
            if (!ok) begin
                timeout("s_ready_wait");
                s_valid_i = 1'b0;
                return;
            end
            sb.push_back({(i == last_idx), exp_d[i]});
            @(posedge clk);
            #1;
            s_valid_i = 1'b0;
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int unsigned n = 0; n < 500; n++) begin
            @(negedge clk);
            if (cmd_ready_o && (sb.size() == 0)) begin ok = 1'b1; break; end
        end
        if (!ok) timeout("idle_wait");
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic run_enc3();
        int d0;
        d0 = done_cnt;
        blk[0] = P1; blk[1] = P2; blk[2] = P3;
        exp_d[0] = C1; exp_d[1] = C2; exp_d[2] = C3;
        send_cmd(1'b0, 3, IV, 1'b0, '0);
        send_blocks(0, 3, 2);
        wait_idle();
        check("enc_done_count", 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin
        int d0;
        int i0;

        // Reset state
        @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_m_valid", 64'(m_valid_o), 64'd0);
        check("rst_s_ready", 64'(s_ready_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        @(posedge clk);
        #1;
        reset_i = 1'b1;
        @(posedge clk);
        #1;

        // Encrypt 3 blocks
        run_enc3();

        // Decrypt the ciphertexts back
        d0 = done_cnt;
        blk[0] = C1; blk[1] = C2; blk[2] = C3;
        exp_d[0] = P1; exp_d[1] = P2; exp_d[2] = P3;
        send_cmd(1'b1, 3, IV, 1'b0, '0);
        send_blocks(0, 3, 2);
        wait_idle();
        check("dec_done_count", 64'(done_cnt - d0), 64'd1);

        // Empty message: no core traffic, done two cycles after accept
        i0 = stub_issued;
        send_cmd(1'b0, 0, IV, 1'b0, '0);
        @(negedge clk);
        check("nblk0_done_early", 64'(done_o), 64'd0);
        @(negedge clk);
        check("nblk0_done", 64'(done_o), 64'd1);
        check("nblk0_cmd_ready", 64'(cmd_ready_o), 64'd1);
        check("nblk0_no_core", 64'(stub_issued - i0), 64'd0);
        @(posedge clk);
        #1;

        // Backpressure: 8 blocks, downstream stalled for 50 cycles
        for (int i = 0; i < 8; i++) begin
            blk[i]   = {8{8'(i + 1)}};
            exp_d[i] = ~blk[i];
        end
        d0 = done_cnt;
        i0 = stub_issued;
        m_ready_i = 1'b0;
        send_cmd(1'b0, 8, IV, 1'b0, '0);
        fork
            send_blocks(0, 8, 7);
            begin
                repeat (50) @(negedge clk);
                check("bp_issued", 64'(stub_issued - i0), 64'd2);
                check("bp_queued", 64'(sb.size()), 64'd2);
                check("bp_s_ready", 64'(s_ready_o), 64'd0);
                check("bp_m_valid", 64'(m_valid_o), 64'd1);
                check("bp_head", m_data_o, exp_d[0]);
                @(posedge clk);
                #1;
                m_ready_i = 1'b1;
            end
        join
        wait_idle();
        check("bp_done_count", 64'(done_cnt - d0), 64'd1);
        check("bp_issued_total", 64'(stub_issued - i0), 64'd8);

        // Reset in the middle of a 4-block message
        blk[0] = P1; blk[1] = P2; blk[2] = P3; blk[3] = 64'h0F0F0F0F0F0F0F0F;
        exp_d[0] = C1; exp_d[1] = C2; exp_d[2] = C3; exp_d[3] = ~blk[3];
        d0 = done_cnt;
        send_cmd(1'b0, 4, IV, 1'b0, '0);
        send_blocks(0, 2, 3);
        reset_i   = 1'b0;
        s_valid_i = 1'b1;
        s_data_i  = blk[2];
        sb.delete();
        @(negedge clk);
        check("mrst_cmd_ready", 64'(cmd_ready_o), 64'd1);
        check("mrst_busy", 64'(busy_o), 64'd0);
        check("mrst_s_ready", 64'(s_ready_o), 64'd0);
        check("mrst_m_valid", 64'(m_valid_o), 64'd0);
        check("mrst_m_last", 64'(m_last_o), 64'd0);
        check("mrst_m_data", m_data_o, 64'd0);
        check("mrst_core_valid", 64'(core_valid_o), 64'd0);
        check("mrst_core_start", 64'(core_start_o), 64'd0);
        check("mrst_core_data", core_data_o, 64'd0);
        check("mrst_core_key1", core_key1_o, 64'd0);
        check("mrst_core_iv", core_iv_o, 64'd0);
        check("mrst_done", 64'(done_o), 64'd0);
        @(posedge clk);
        #1;
        reset_i   = 1'b1;
        s_valid_i = 1'b0;
        repeat (4) @(negedge clk);
        check("mrst_no_done", 64'(done_cnt - d0), 64'd0);
        check("mrst_idle_m_valid", 64'(m_valid_o), 64'd0);
        @(posedge clk);
        #1;
        run_enc3();

`ifdef CBCTDES_CTRL_CHAIN_EN
        // Chained messages: blocks 1-2, then block 3 continuing the chain
        blk[0] = P1; blk[1] = P2;
        exp_d[0] = C1; exp_d[1] = C2;
        send_cmd(1'b0, 2, IV, 1'b0, '0);
        send_blocks(0, 2, 1);
        wait_idle();
        check("chain_iv_next", iv_next_o, C2);
        blk[0] = P3;
        exp_d[0] = C3;
        send_cmd(1'b0, 1, 64'hDEADBEEFDEADBEEF, 1'b1, C2);
        send_blocks(0, 1, 0);
        wait_idle();
        check("chain_iv_next2", iv_next_o, C3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
